cla_divider: RTL and testbench



---
 rtl/cla_divider_pkg.sv | 27 ++
 rtl/cla_divider_if.sv | 28 ++
 rtl/cla_subtractor.sv | 41 ++++
 rtl/cla_divider.sv | 168 ++++++++++++++++
 tb/tb_cla_divider.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/cla_divider_pkg.sv
// Shared types and helpers for the iterative CLA-based divider.
// The FIX state is only reachable when CLA_DIVIDER_SIGNED_EN is defined.
package cla_divider_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    FIX  = 2'd3
  } state_t;

  // Bits needed to count 0..v-1 (at least 1)
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/cla_divider_if.sv
// Operand/result valid-ready bus for cla_divider.
interface cla_divider_if
  import cla_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/cla_subtractor.sv
// a - b as a + ~b + 1: 4-bit groups with full lookahead inside, ripple between groups.
module cla_subtractor #(
  parameter int unsigned WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             no_borrow
);

  localparam int unsigned NG = (WIDTH + 3) / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  assign g    = a & ~b;
  assign p    = a ^ ~b;
  assign c[0] = 1'b1;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    localparam int LO = gi * 4;
    localparam int HI = (LO + 3 < int'(WIDTH) - 1) ? LO + 3 : int'(WIDTH) - 1;
    for (genvar j = LO; j <= HI; j++) begin : g_bit
      // Every carry in the group is a sum of products over the group carry-in
      logic [j-LO:0] t;
      for (genvar k = LO; k <= j; k++) begin : g_term
        if (k == j) begin : g_gen
          assign t[k-LO] = g[k];
        end else begin : g_prop
          assign t[k-LO] = g[k] & (&p[j:k+1]);
        end
      end
      assign c[j+1] = (|t) | ((&p[j:LO]) & c[LO]);
    end
  end

  assign diff      = p ^ c[WIDTH-1:0];
  assign no_borrow = c[WIDTH];

endmodule

// File: rtl/cla_divider.sv
// Iterative restoring divider, one CLA trial subtraction per cycle.
// Define CLA_DIVIDER_SIGNED_EN for two's-complement operands (adds the FIX state).
module cla_divider
  import cla_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  cla_divider_if.slave  bus
);

  localparam int unsigned CW = clog2(WIDTH);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("cla_divider: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t           state, state_n;
  logic [WIDTH-1:0] rem, rem_n, quo, quo_n, dvsr, dvsr_n;
  logic [WIDTH-1:0] q_out, q_out_n, r_out, r_out_n;
  logic [CW-1:0]    count, count_n;
  logic             dbz, dbz_n, ov, ov_n;
  logic [WIDTH:0]   rem_sh, trial;
  logic             no_borrow, take;

`ifdef CLA_DIVIDER_SIGNED_EN
  logic neg_q, neg_q_n, neg_r, neg_r_n;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction
`endif

  assign rem_sh = {rem, quo[WIDTH-1]};

  cla_subtractor #(.WIDTH(WIDTH + 1)) u_sub (
    .a         (rem_sh),
    .b         ({1'b0, dvsr}),
    .diff      (trial),
    .no_borrow (no_borrow)
  );

  // Carry-out and a clear sign bit coincide because rem < divisor always holds
  assign take = no_borrow & ~trial[WIDTH];

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = ov;
  assign bus.quotient    = q_out;
  assign bus.remainder   = r_out;
  assign bus.div_by_zero = dbz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      count <= '0;
      q_out <= '0;
      r_out <= '0;
      dbz   <= 1'b0;
      ov    <= 1'b0;
`ifdef CLA_DIVIDER_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else begin
      state <= state_n;
      rem   <= rem_n;
      quo   <= quo_n;
      dvsr  <= dvsr_n;
      count <= count_n;
      q_out <= q_out_n;
      r_out <= r_out_n;
      dbz   <= dbz_n;
      ov    <= ov_n;
`ifdef CLA_DIVIDER_SIGNED_EN
      neg_q <= neg_q_n;
      neg_r <= neg_r_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    rem_n   = rem;
    quo_n   = quo;
    dvsr_n  = dvsr;
    count_n = count;
    q_out_n = q_out;
    r_out_n = r_out;
    dbz_n   = dbz;
    ov_n    = ov;
`ifdef CLA_DIVIDER_SIGNED_EN
    neg_q_n = neg_q;
    neg_r_n = neg_r;
`endif
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          rem_n   = '0;
          count_n = '0;
          dbz_n   = 1'b0;
`ifdef CLA_DIVIDER_SIGNED_EN
          quo_n   = mag(bus.dividend);
          dvsr_n  = mag(bus.divisor);
          neg_q_n = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          neg_r_n = bus.dividend[WIDTH-1];
`else
          quo_n   = bus.dividend;
          dvsr_n  = bus.divisor;
`endif
          if (bus.divisor == '0) begin
            // Zero divisor: result is fixed, DONE presents it on the next edge
            quo_n   = '1;
            rem_n   = bus.dividend;
            dbz_n   = 1'b1;
            state_n = DONE;
`ifdef CLA_DIVIDER_SIGNED_EN
            neg_q_n = 1'b0;
            neg_r_n = 1'b0;
`endif
          end else begin
            state_n = RUN;
          end
        end
      end
      RUN: begin
        quo_n   = {quo[WIDTH-2:0], take};
        rem_n   = take ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        count_n = count + CW'(1);
        if (count == CW'(WIDTH - 1)) begin
`ifdef CLA_DIVIDER_SIGNED_EN
          state_n = FIX;
`else
          state_n = DONE;
          ov_n    = 1'b1;
          q_out_n = quo_n;
          r_out_n = rem_n;
`endif
        end
      end
`ifdef CLA_DIVIDER_SIGNED_EN
      FIX: begin
        quo_n   = neg_q ? (~quo + WIDTH'(1)) : quo;
        rem_n   = neg_r ? (~rem + WIDTH'(1)) : rem;
        state_n = DONE;
        ov_n    = 1'b1;
        q_out_n = quo_n;
        r_out_n = rem_n;
      end
`endif
      DONE: begin
        if (!ov) begin
          ov_n    = 1'b1;
          q_out_n = quo;
          r_out_n = rem;
        end else if (bus.out_ready) begin
          ov_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cla_divider.sv
// Scoreboard bench for cla_divider (WIDTH=8) plus direct checks of cla_subtractor.
module tb_cla_divider;
  import cla_divider_pkg::*;

  localparam int unsigned W = 8;
`ifdef CLA_DIVIDER_SIGNED_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla_divider_if #(.WIDTH(W)) bus ();
  cla_divider #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [8:0] sa, sb, sd;
  logic       snb;
  cla_subtractor #(.WIDTH(9)) u_sub (.a(sa), .b(sb), .diff(sd), .no_borrow(snb));

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   hs_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every result handshake pops and compares one expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      check("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("quotient", 32'(bus.quotient), 32'(e.q));
        check("remainder", 32'(bus.remainder), 32'(e.r));
        check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dz));
      end
      hs_count++;
    end
  end

  task automatic push_exp(input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    exp_t e;
    e.q  = eq;
    e.r  = er;
    e.dz = edz;
    exp_q.push_back(e);
  endtask

  task automatic accept(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input bit push,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    int n = 0;
    while (!bus.in_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    if (push) push_exp(eq, er, edz);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int lat);
    int n = 0;
    while (!bus.out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(lat));
  endtask

  task automatic do_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz, input int lat);
    accept(dvd, dvs, 1'b1, eq, er, edz);
    wait_valid(lat);
  endtask

  task automatic sub_check(input logic [8:0] a, input logic [8:0] b, input logic [8:0] d, input logic nb);
    sa = a;
    sb = b;
    #1;
    check("sub_diff", 32'(sd), 32'(d));
    check("sub_no_borrow", 32'(snb), 32'(nb));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  hb;
    bit  seen;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    sa = '0;
    sb = '0;

    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
    check("rst_div_by_zero", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    sub_check(9'd300, 9'd45, 9'd255, 1'b1);
    sub_check(9'd5, 9'd7, 9'h1FE, 1'b0);
    sub_check(9'd0, 9'd0, 9'd0, 1'b1);
    sub_check(9'd511, 9'd511, 9'd0, 1'b1);
    sub_check(9'h100, 9'h0F1, 9'h00F, 1'b1);
    sub_check(9'd0, 9'd1, 9'h1FF, 1'b0);
    @(posedge clk); #1;

`ifdef CLA_DIVIDER_SIGNED_EN
    do_op(8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, LAT);
    do_op(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, LAT);
    do_op(8'h64, 8'hF7, 8'hF5, 8'h01, 1'b0, LAT);
    do_op(8'h9C, 8'h09, 8'hF5, 8'hFF, 1'b0, LAT);
    do_op(8'hC8, 8'h07, 8'hF8, 8'h00, 1'b0, LAT);
    do_op(8'h80, 8'h00, 8'hFF, 8'h80, 1'b1, 1);
`else
    do_op(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, LAT);
    do_op(8'd0, 8'd5, 8'd0, 8'd0, 1'b0, LAT);
    do_op(8'd7, 8'd7, 8'd1, 8'd0, 1'b0, LAT);
    do_op(8'd6, 8'd255, 8'd0, 8'd6, 1'b0, LAT);
    do_op(8'd250, 8'd16, 8'd15, 8'd10, 1'b0, LAT);
`endif
    do_op(8'd5, 8'd0, 8'd255, 8'd5, 1'b1, 1);

    // Back-to-back: second operands held while busy, taken only after the first result leaves
    accept(8'd255, 8'd1, 1'b1, 8'd255, 8'd0, 1'b0);
    bus.in_valid = 1'b1;
    bus.dividend = 8'd3;
    bus.divisor  = 8'd200;
    hb = hs_count;
    n  = 0;
    while (!bus.in_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_handshake_first", 32'(hs_count - hb), 32'd1);
    check("b2b_ready_cycle", 32'(n), 32'(LAT + 1));
    push_exp(8'd0, 8'd3, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_valid(LAT);

    // Stalled sink: result holds, busy inputs ignored
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    accept(8'd100, 8'd9, 1'b1, 8'd11, 8'd1, 1'b0);
    wait_valid(LAT);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.dividend = 8'd50;
      bus.divisor  = 8'd5;
      @(posedge clk); #1;
      check("stall_quotient", 32'(bus.quotient), 32'd11);
      check("stall_remainder", 32'(bus.remainder), 32'd1);
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_out_valid", 32'(bus.out_valid), 32'd0);
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("ignored_inputs_no_result", 32'(bus.out_valid), 32'd0);

    // Reset during RUN discards the operation
    accept(8'd200, 8'd7, 1'b0, 8'd0, 8'd0, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_quotient", 32'(bus.quotient), 32'd0);
    check("midrst_remainder", 32'(bus.remainder), 32'd0);
    check("midrst_div_by_zero", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("midrst_no_stale_valid", 32'(seen), 32'd0);

    do_op(8'd100, 8'd9, 8'd11, 8'd1, 1'b0, LAT);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
